// File: rtl/uart_pkg.sv
// uart_pkg: receiver/transmitter shared FSM encodings and default frame geometry.
package uart_pkg;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_BREAK  = 3'd5;
  localparam int UART_DATA_BITS  = 8;
  localparam int UART_OVERSAMPLE = 16;
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for the idle-high serial line, reset to 1.
module uart_rx_sync (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [1:0] ff;
  always_ff @(posedge clock) begin
    if (reset) ff <= 2'b11;
    else ff <= {ff[0], d};
  end
  assign q = ff[1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver driven by a 16x oversampling tick.
// Define UART_PARITY_EN to add an even-parity bit and the parity_err output.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int STOP_TICKS = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
`ifdef UART_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 frame_err
);
  localparam int NW = $clog2(DATA_BITS);
  localparam logic [3:0] S_MID  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] S_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] S_STOP = 4'(STOP_TICKS - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DATA_BITS - 1);
  logic                 rs;
  logic [2:0]           state;
  logic [3:0]           s_cnt;
  logic [NW-1:0]        n_cnt;
  logic [DATA_BITS-1:0] shreg;
`ifdef UART_PARITY_EN
  logic                 par_bit;
`endif
  uart_rx_sync u_sync (
    .clock(clock),
    .reset(reset),
    .d    (rx),
    .q    (rs)
  );
  // Start bit is verified at its midpoint; every later sample lands one full bit later.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      s_cnt     <= '0;
      n_cnt     <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      rx_done <= 1'b0;
      case (state)
        ST_IDLE:
          if (!rs) begin
            state <= ST_START;
            s_cnt <= '0;
          end
        ST_START:
          if (tick) begin
            if (s_cnt == S_MID) begin
              state <= rs ? ST_IDLE : ST_DATA;
              s_cnt <= '0;
              n_cnt <= '0;
            end else s_cnt <= s_cnt + 4'd1;
          end
        ST_DATA:
          if (tick) begin
            if (s_cnt == S_LAST) begin
              shreg <= {rs, shreg[DATA_BITS-1:1]};
              s_cnt <= '0;
`ifdef UART_PARITY_EN
              if (n_cnt == N_LAST) state <= ST_PARITY;
`else
              if (n_cnt == N_LAST) state <= ST_STOP;
`endif
              else n_cnt <= n_cnt + 1'b1;
            end else s_cnt <= s_cnt + 4'd1;
          end
`ifdef UART_PARITY_EN
        ST_PARITY:
          if (tick) begin
            if (s_cnt == S_LAST) begin
              par_bit <= rs;
              s_cnt   <= '0;
              state   <= ST_STOP;
            end else s_cnt <= s_cnt + 4'd1;
          end
`endif
        ST_STOP:
          if (tick) begin
            if (s_cnt == S_STOP) begin
              rx_data   <= shreg;
              rx_done   <= 1'b1;
              frame_err <= ~rs;
`ifdef UART_PARITY_EN
              parity_err <= (^shreg) ^ par_bit;
`endif
              s_cnt     <= '0;
              state     <= rs ? ST_IDLE : ST_BREAK;
            end else s_cnt <= s_cnt + 4'd1;
          end
        // A held-low line reports one framing error, then waits for the line to recover.
        ST_BREAK:
          if (rs) state <= ST_IDLE;
        default:
          state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed scoreboard bench for uart_rx; tick is divided down to one per 4 clocks.
module tb_uart_rx;
  localparam int DIV = 4;
  localparam int BIT = 16 * DIV;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_err;
`ifdef UART_PARITY_EN
  logic       parity_err;
`endif
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int div_cnt = 0;
  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;
  exp_t sb[$];
  always #10 clock = ~clock;
  always @(posedge clock) begin
    if (div_cnt == DIV - 1) begin
      div_cnt <= 0;
      tick    <= 1'b1;
    end else begin
      div_cnt <= div_cnt + 1;
      tick    <= 1'b0;
    end
  end
  uart_rx dut (
    .clock     (clock),
    .reset     (reset),
    .tick      (tick),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
`ifdef UART_PARITY_EN
    .parity_err(parity_err),
`endif
    .frame_err (frame_err)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clock) begin
    if (rx_done === 1'b1) begin
      exp_t e;
      done_cnt++;
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_frame: observed rx_data %0h expected no rx_done", rx_data);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("rx_data", 32'(rx_data), 32'(e.d));
        chk("frame_err", 32'(frame_err), 32'(e.fe));
`ifdef UART_PARITY_EN
        chk("parity_err", 32'(parity_err), 32'(e.pe));
`endif
      end
    end
  end
  task automatic send_bit(input logic b);
    rx = b;
    repeat (BIT) @(negedge clock);
  endtask
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic flip);
    sb.push_back({d, ~stop, flip});
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_PARITY_EN
    send_bit((^d) ^ flip);
`endif
    send_bit(stop);
  endtask
  task automatic drain();
    for (int i = 0; i < 20 * BIT && sb.size() != 0; i++) @(negedge clock);
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL drain_timeout: observed %0d pending expected 0", sb.size());
    end
  endtask
  initial begin
    repeat (3) @(negedge clock);
    chk("reset_rx_data", 32'(rx_data), 32'h0);
    chk("reset_rx_done", 32'(rx_done), 32'h0);
    chk("reset_frame_err", 32'(frame_err), 32'h0);
    reset = 1'b0;
    repeat (BIT) @(negedge clock);
    send_frame(8'hA5, 1'b1, 1'b0);
    drain();
    send_bit(1'b1);
    chk("t1_done_cnt", 32'(done_cnt), 32'd1);
    rx = 1'b0;
    repeat (4 * DIV) @(negedge clock);
    rx = 1'b1;
    repeat (2 * BIT) @(negedge clock);
    chk("t2_done_cnt", 32'(done_cnt), 32'd1);
    chk("t2_rx_data", 32'(rx_data), 32'hA5);
    send_frame(8'h3C, 1'b0, 1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    rx = 1'b1;
    repeat (2 * BIT) @(negedge clock);
    drain();
    chk("t3_done_cnt", 32'(done_cnt), 32'd2);
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    drain();
    send_bit(1'b1);
    chk("t4_done_cnt", 32'(done_cnt), 32'd4);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0] ? 1'b0 : 1'b1);
    rx = 1'b1;
    repeat (BIT / 2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("t5_rx_data", 32'(rx_data), 32'h0);
    chk("t5_rx_done", 32'(rx_done), 32'h0);
    chk("t5_frame_err", 32'(frame_err), 32'h0);
    reset = 1'b0;
    repeat (12 * BIT) @(negedge clock);
    chk("t5_no_frame", 32'(done_cnt), 32'd4);
    send_frame(8'h81, 1'b1, 1'b0);
    drain();
    send_bit(1'b1);
    chk("t5_done_cnt", 32'(done_cnt), 32'd5);
`ifdef UART_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0);
    send_frame(8'h07, 1'b1, 1'b1);
    drain();
    send_bit(1'b1);
    chk("t6_done_cnt", 32'(done_cnt), 32'd7);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
